// File: rtl/quet_led7_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package quet_led7_pkg;

    // BCD code the segment decoder renders as a dash.
    localparam logic [3:0] BCD_DASH = 4'hA;

    // Default scan and blink settings.
    localparam int unsigned DEF_NUM_DIGITS   = 8;
    localparam int unsigned DEF_SCAN_DIV     = 50000;
    localparam int unsigned DEF_DEAD_CYC     = 4;
    localparam int unsigned DEF_BLINK_FRAMES = 64;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/quet_led7_if.sv
// Display bus: shadow inputs and load handshake from the time counters,
// scan outputs towards the segment decoder and anode drivers.
interface quet_led7_if
    import quet_led7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS
) ();

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    load_req;
    logic                    load_ack;
    logic [3:0]              data;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_start;

    // Requester side (time counters / bench).
    modport master (
        output digits_in, blank_in, blink_mask, load_req,
        input  load_ack, data, an_n, frame_start
    );

    // Scan controller side.
    modport slave (
        input  digits_in, blank_in, blink_mask, load_req,
        output load_ack, data, an_n, frame_start
    );

endinterface

// File: rtl/quet_led7_timebase.sv
// Scan timebase: slot prescaler, digit index and frame/blink counters.
module quet_led7_timebase
    import quet_led7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
    parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES,
    localparam int unsigned PRE_W = cnt_width(SCAN_DIV),
    localparam int unsigned IDX_W = cnt_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PRE_W-1:0] pre_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             tick_o,
    output logic             fb_o,
    output logic             blink_phase_o
);

    localparam int unsigned      FRM_W    = cnt_width(BLINK_FRAMES);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             blink_q, blink_d;
    logic             tick, fb;

    assign tick = (pre_q == PRE_LAST);
    assign fb   = tick && (idx_q == IDX_LAST);

    // Next-state for the prescaler, slot index and blink counters.
    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;
        idx_d   = idx_q;
        frm_d   = frm_q;
        blink_d = blink_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (fb) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                blink_d = ~blink_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    // Timebase state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            blink_q <= blink_d;
        end
    end

    assign pre_o         = pre_q;
    assign idx_o         = idx_q;
    assign tick_o        = tick;
    assign fb_o          = fb;
    assign blink_phase_o = blink_q;

endmodule

// File: rtl/quet_led7.sv
// Seven-segment scan controller: double-buffered digit codes, blanking,
// blinking and dead time, with registered decoder and anode outputs.
module quet_led7
    import quet_led7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
    parameter int unsigned DEAD_CYC     = DEF_DEAD_CYC,
    parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic         clk,
    input  logic         rst,
    quet_led7_if.slave   bus
);

    localparam int unsigned      PRE_W    = cnt_width(SCAN_DIV);
    localparam int unsigned      IDX_W    = cnt_width(NUM_DIGITS);
    localparam logic [PRE_W-1:0] DEAD_PRE = PRE_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;
    logic             tick, fb, blink_phase;

    quet_led7_timebase #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timebase (
        .clk           (clk),
        .rst           (rst),
        .pre_o         (pre),
        .idx_o         (idx),
        .tick_o        (tick),
        .fb_o          (fb),
        .blink_phase_o (blink_phase)
    );

    // Active (displayed) buffer.
    logic [4*NUM_DIGITS-1:0] act_dig_q;
    logic [NUM_DIGITS-1:0]   act_blank_q;
    logic [NUM_DIGITS-1:0]   act_mask_q;

    // Output registers.
    logic [3:0]            data_q, data_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  ack_q, ack_d;
    logic                  fs_q, fs_d;

    logic capture;

    // Shadow inputs are only taken at a frame boundary, so a frame never mixes old and new codes.
    assign capture = fb && bus.load_req;

    // Active buffer load; reset leaves the display dark until the first load.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_dig_q   <= '0;
            act_blank_q <= '1;
            act_mask_q  <= '0;
        end else if (capture) begin
            act_dig_q   <= bus.digits_in;
            act_blank_q <= bus.blank_in;
            act_mask_q  <= bus.blink_mask;
        end
    end

    // Decoder code, anode enable and handshake pulses for the next cycle.
    always_comb begin
        data_d = act_dig_q[{idx, 2'b00} +: 4];
        an_n_d = '1;
        if ((pre >= DEAD_PRE) && !act_blank_q[idx] && !(blink_phase && act_mask_q[idx])) begin
            an_n_d[idx] = 1'b0;
        end
        fs_d  = tick && (idx == IDX_LAST);
        ack_d = capture;
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            an_n_q <= '1;
            ack_q  <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            an_n_q <= an_n_d;
            ack_q  <= ack_d;
            fs_q   <= fs_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.an_n        = an_n_q;
    assign bus.load_ack    = ack_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_quet_led7.sv
// Self-checking bench for quet_led7 against a cycle-count based reference model.
module tb_quet_led7;
    import quet_led7_pkg::*;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 8;
    localparam int unsigned DC = 2;
    localparam int unsigned BF = 2;
    localparam int unsigned FR = ND * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quet_led7_if #(.NUM_DIGITS(ND)) bus ();

    quet_led7 #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .DEAD_CYC     (DC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: state is the number of clocks since reset release plus the active buffer.
    int unsigned m_n;
    logic [3:0]  m_dig   [ND];
    bit          m_blank [ND];
    bit          m_mask  [ND];

    int total = 0;
    int bad   = 0;
    bit seen_ack, seen_fs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: predict outputs from the model, advance both, compare.
    task automatic step();
        logic [3:0]    e_data;
        logic [ND-1:0] e_an;
        bit            e_fs, e_ack;
        int unsigned   pre, idx, ph;
        e_data = '0; e_an = '1; e_fs = 0; e_ack = 0;
        if (!rst) begin
            pre    = m_n % SD;
            idx    = (m_n / SD) % ND;
            ph     = ((m_n / FR) / BF) % 2;
            e_data = m_dig[idx];
            if (pre >= DC && !m_blank[idx] && !(ph == 1 && m_mask[idx]))
                e_an[idx] = 1'b0;
            e_fs  = (m_n % FR == FR - 1);
            e_ack = e_fs && bus.load_req;
        end
        @(posedge clk);
        if (rst) begin
            m_n = 0;
            for (int k = 0; k < ND; k++) begin
                m_dig[k] = 4'h0; m_blank[k] = 1; m_mask[k] = 0;
            end
        end else begin
            if (e_ack) begin
                for (int k = 0; k < ND; k++) begin
                    m_dig[k]   = bus.digits_in[4*k +: 4];
                    m_blank[k] = bus.blank_in[k];
                    m_mask[k]  = bus.blink_mask[k];
                end
            end
            m_n++;
        end
        #1;
        check("data", 32'(bus.data), 32'(e_data));
        check("an_n", 32'(bus.an_n), 32'(e_an));
        check("frame_start", 32'(bus.frame_start), 32'(e_fs));
        check("load_ack", 32'(bus.load_ack), 32'(e_ack));
        seen_ack = bus.load_ack;
        seen_fs  = bus.frame_start;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int r);
        for (int i = 0; i < int'(FR) && int'(m_n % FR) != r; i++) step();
    endtask

    // Present shadow values, hold the request until acknowledged (bounded).
    task automatic load(input logic [4*ND-1:0] d, input logic [ND-1:0] b,
                        input logic [ND-1:0] m, output int lat);
        bit got = 0;
        lat = 0;
        bus.digits_in = d; bus.blank_in = b; bus.blink_mask = m; bus.load_req = 1'b1;
        for (int k = 0; k < int'(FR) + 2 && !got; k++) begin
            step();
            lat++;
            got = seen_ack;
        end
        check("ack_within_frame", 32'(got), 32'd1);
        bus.load_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, fs1, fs2, acks, lit;
        bus.digits_in = '0; bus.blank_in = '0; bus.blink_mask = '0; bus.load_req = 1'b0;

        // 1: dark after reset, frame_start cadence, no ack.
        rst = 1'b1; run(3); rst = 1'b0;
        fs1 = 0; fs2 = 0; acks = 0; lit = 0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (seen_fs) begin if (fs1 == 0) fs1 = i; else fs2 = i; end
            if (seen_ack) acks++;
            if (bus.an_n != 4'b1111) lit++;
        end
        check("t1_fs_first", 32'(fs1), 32'd32);
        check("t1_fs_second", 32'(fs2), 32'd64);
        check("t1_no_ack", 32'(acks), 32'd0);
        check("t1_dark", 32'(lit), 32'd0);

        // 2: plain load, ack right after the first frame boundary.
        load({4'h1, 4'h3, 4'h5, 4'h9}, 4'b0000, 4'b0000, lat);
        check("t2_ack_latency", 32'(lat), 32'd32);
        run(FR);

        // 3: blink on digits 0..1.
        load({4'h4, 4'h6, 4'h8, 4'h2}, 4'b0000, 4'b0011, lat);
        run(4 * FR);

        // 4: digit 3 blanked, invalid code passthrough.
        load({4'hC, 4'hC, 4'h7, 4'h2}, 4'b1000, 4'b0000, lat);
        lit = 0;
        for (int i = 0; i < int'(FR); i++) begin
            step();
            if (bus.an_n[3] == 1'b0) lit++;
        end
        check("t4_blank3", 32'(lit), 32'd0);

        // 5: aborted request captures nothing; re-raised request is served.
        run_to(5);
        bus.digits_in = 16'h7777; bus.blank_in = '0; bus.blink_mask = '0;
        bus.load_req = 1'b1; run(5); bus.load_req = 1'b0;
        acks = 0;
        for (int i = 0; i < int'(FR) + 2; i++) begin step(); if (seen_ack) acks++; end
        check("t5_no_ack", 32'(acks), 32'd0);
        load(16'h0123, 4'b0000, 4'b0000, lat);
        run(FR);

        // 6: reset in slot 2 with a pending request.
        run_to(17);
        bus.digits_in = 16'h4321; bus.blank_in = '0; bus.blink_mask = 4'b0100;
        bus.load_req = 1'b1;
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_dark", 32'(bus.an_n), 32'hF);
        check("t6_no_ack", 32'(bus.load_ack), 32'd0);
        load(16'h4321, 4'b0000, 4'b0100, lat);
        check("t6_ack_latency", 32'(lat), 32'd32);
        run(FR);

        // Randomized traffic: loads, aborted requests and resets.
        repeat (30) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                bus.load_req = 1'($urandom);
                rst = 1'b1; run(int'($urandom_range(1, 3))); rst = 1'b0;
                bus.load_req = 1'b0;
            end else if (r < 4) begin
                bus.digits_in = 16'($urandom); bus.blank_in = 4'($urandom);
                bus.blink_mask = 4'($urandom); bus.load_req = 1'b1;
                for (int k = int'($urandom_range(1, 40)); k > 0; k--) begin
                    step();
                    if (seen_ack) break;
                end
                bus.load_req = 1'b0;
            end else begin
                run(int'($urandom_range(0, 40)));
                load(16'($urandom), 4'($urandom), 4'($urandom), lat);
            end
            run(int'($urandom_range(1, 2 * FR)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quet_led7.md
Name: quet_led7

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits in the clock display.
- Each scan slot selects one digit, presents that digit's 4-bit BCD code to the shared BCD-to-segment decoder, and drives that digit's active-low anode enable.
- Owns the per-digit blanking, field blinking used in time-setting mode, and anti-ghosting dead time.
- Owns a double-buffered load handshake so the time counters update the display only at frame boundaries (no tearing).

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (>=2)
SCAN_DIV, 50000, clk cycles per digit slot (>= DEAD_CYC+2)
DEAD_CYC, 4, cycles at start of each slot with all anodes off
BLINK_FRAMES, 64, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
digits_in  in  4*NUM_DIGITS  shadow BCD codes; digit k at [4k+3:4k], digit 0 = rightmost
blank_in  in  NUM_DIGITS  shadow per-digit blank (1 = dark)
blink_mask  in  NUM_DIGITS  shadow per-digit blink enable
load_req  in  1  request to transfer shadow inputs to the active buffer
load_ack  out  1  one-cycle pulse: shadow inputs captured
data  out  4  BCD code of the current digit, to the segment decoder
an_n  out  NUM_DIGITS  active-low anode enables, at most one low
frame_start  out  1  one-cycle pulse when slot 0 begins

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values:
  - pre=0, idx=0, frame_cnt=0, blink_phase=0.
  - Active buffer: digits 0, blank all 1, mask 0.
  - Outputs: an_n all 1, data=0, load_ack=0, frame_start=0.
  - The display is dark until the first load.
- Prescaler: pre counts 0..SCAN_DIV-1 and wraps. tick = (pre==SCAN_DIV-1).
  - On tick, idx advances to idx+1; it wraps from NUM_DIGITS-1 to 0.
- Frame boundary: fb = tick && idx==NUM_DIGITS-1.
- Blink:
  - On fb, frame_cnt increments.
  - When frame_cnt reaches BLINK_FRAMES-1 at fb, it clears and blink_phase toggles.
- Load handshake:
  - The requester holds load_req high, with shadow inputs stable, until it sees load_ack.
  - If load_req=1 on an fb cycle, the active buffer captures all three shadow inputs at that edge, and load_ack=1 for the following single cycle.
  - load_req sampled at any other cycle has no effect.
  - If the requester drops load_req before fb, nothing is captured.
  - Latency from request to ack: at most one frame (NUM_DIGITS*SCAN_DIV cycles) plus 1 cycle.
- Registered outputs (1-cycle latency from state):
  - data = active digit[idx].
  - frame_start = 1 in the cycle after fb.
  - an_n[idx] = 0 only if all of the following hold:
    - pre >= DEAD_CYC;
    - active blank[idx] == 0;
    - NOT (blink_phase && mask[idx]).
  - All other an_n bits are 1.
- Blanked or blinked slot: the slot still consumes its full time; data still presents the code; only the anode stays off.
- Simultaneous events:
  - A capture and a blink toggle on the same fb both take effect for the new frame's slot 0.
  - rst together with load_req: reset wins, and no ack is issued.
- Reset mid-frame: the scan restarts at slot 0 with a dark display. A pending request must be re-held after reset to be served.
- Invalid BCD codes (10..15) pass through unchanged; the decoder renders them as a dash.
- Widths:
  - pre is clog2(SCAN_DIV) wide.
  - idx is clog2(NUM_DIGITS) wide.
  - frame_cnt is clog2(BLINK_FRAMES) wide (minimum 1).
  - No arithmetic overflow beyond the wrap points above.

Decomposition:
- Shared display package holds:
  - BCD code constant for dash (4'hA);
  - default scan/blink constants;
  - digit index type width function.
- One natural sub-module, quet_led7_timebase: the prescaler, idx counter and frame/blink counters, exporting tick, fb, idx and blink_phase.
- The top level holds the shadow/active buffers, the handshake and the output registers.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2 (frame = 32 cycles).
1. Reset for 3 cycles, then run 64 cycles with no load -> an_n stays 4'b1111 throughout; frame_start pulses at cycles 32 and 64 after reset release; load_ack never asserts.
2. Load digits {9,5,3,1}, blank=0, mask=0, hold load_req -> load_ack pulses once, the cycle after the first fb. Next frame: slot k shows data=digit k; an_n = ~(1<<k) for slot cycles 2..7 and 4'b1111 for cycles 0..1.
3. Load with mask=4'b0011 -> digits 0..1 lit for 2 frames, dark for the next 2 frames, repeating. Digits 2..3 are always lit. data still cycles through all codes.
4. Load with blank=4'b1000 and digit 3 = 4'hC -> slot 3 is never enabled; slot 2 shows data=4'hC passthrough when its code is 4'hC.
5. Raise load_req mid-frame, then drop it 5 cycles later before fb -> no load_ack and the active buffer is unchanged. Re-raise and hold -> ack at the next fb.
6. Assert rst during slot 2 while load_req is high -> next cycle an_n=4'b1111, idx=0, no ack. After release, the request held high is acked at the first fb (cycle 32).
